// File: rtl/multi_counter_variants_pkg.sv
// Shared opcode encoding for the multi-counter family, plus a width helper
// that keeps zero-width vectors out of degenerate parameterisations.
package multi_counter_variants_pkg;

   typedef enum logic [1:0] {
      OP_INIT = 2'd0,
      OP_INCR = 2'd1,
      OP_DECR = 2'd2,
      OP_QRY  = 2'd3
   } op_t;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/multi_counter_sched_tagq.sv
// In-order FIFO of requester indices that own outstanding queries.
// The caller never pushes when full and never pops when empty.
module multi_counter_sched_tagq
   import multi_counter_variants_pkg::*;
#(
   parameter int unsigned D = 4,
   parameter int unsigned W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(D+1)-1:0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = clog2_min1(D);
   localparam int unsigned CW = $clog2(D + 1);

   logic [W-1:0]  mem_q [D];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wrap_inc(wr_q);
         if (pop)  rd_q <= wrap_inc(rd_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_dat;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign full  = (cnt_q == CW'(D));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/multi_counter_sched.sv
// Round-robin command scheduler in front of the shared counter datapath;
// routes query responses back to the requester that issued them.
module multi_counter_sched
   import multi_counter_variants_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned N = 32,
   parameter int unsigned R = 4,
   parameter int unsigned D = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [R-1:0]                   req_vld,
   input  op_t  [R-1:0]                   req_op,
   input  logic [R-1:0][$clog2(N)-1:0]    req_id,
   input  logic [R-1:0][W-1:0]            req_dat,
   output logic [R-1:0]                   req_acc,
   input  logic                           busy,
   output logic                           cmd_pass_r,
   output op_t                            cmd_op_r,
   output logic [$clog2(N)-1:0]           cmd_id_r,
   output logic [W-1:0]                   cmd_dat_r,
   input  logic                           rsp_pass,
   input  logic [W-1:0]                   rsp_dat,
   output logic [R-1:0]                   rsp_vld_r,
   output logic [W-1:0]                   rsp_dat_r,
   output logic                           err_r
);

   localparam int unsigned RW = $clog2(R);

   logic [RW-1:0]          ptr_q, ptr_d;
   logic                   gnt_vld;
   logic [RW-1:0]          gnt_idx;
   logic [RW-1:0]          idx;
   int unsigned            cand;
   logic                   q_push, q_pop, q_full, q_empty;
   logic [RW-1:0]          q_head;
   logic [$clog2(D+1)-1:0] q_count;

   // Eligibility, rotating search from ptr_q and the pointer update share one block.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      cand    = 0;
      req_acc = '0;
      for (int unsigned k = 0; k < R; k++) begin
         cand = (32'(ptr_q) + k) % R;
         idx  = RW'(cand);
         if (!gnt_vld && !rst && !busy && req_vld[idx] &&
             (req_op[idx] != OP_QRY || !q_full)) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
      req_acc[gnt_idx] = gnt_vld;
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = (gnt_idx == RW'(R - 1)) ? '0 : gnt_idx + RW'(1);
   end

   assign q_push = gnt_vld && (req_op[gnt_idx] == OP_QRY);
   // Pop-on-empty is dropped here, so a push into an empty queue never pairs with a pop.
   assign q_pop  = rsp_pass && !q_empty;

   multi_counter_sched_tagq #(
      .D (D),
      .W (RW)
   ) u_tagq (
      .clk      (clk),
      .rst      (rst),
      .push     (q_push),
      .push_dat (gnt_idx),
      .pop      (q_pop),
      .head     (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         cmd_pass_r <= 1'b0;
         rsp_vld_r  <= '0;
         err_r      <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         cmd_pass_r <= gnt_vld;
         rsp_vld_r  <= '0;
         if (q_pop) rsp_vld_r[q_head] <= 1'b1;
         if (rsp_pass && q_empty) err_r <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (gnt_vld) begin
         cmd_op_r  <= req_op[gnt_idx];
         cmd_id_r  <= req_id[gnt_idx];
         cmd_dat_r <= req_dat[gnt_idx];
      end
      if (q_pop) rsp_dat_r <= rsp_dat;
   end

endmodule

// File: tb/tb_multi_counter_sched.sv
// Directed bench for multi_counter_sched: arbitration order, busy stall,
// tag-queue full/ordering, empty-response error and reset mid-operation.
module tb_multi_counter_sched;
   import multi_counter_variants_pkg::*;

   localparam int unsigned W = 32;
   localparam int unsigned N = 32;
   localparam int unsigned R = 4;
   localparam int unsigned D = 4;

   logic                  clk;
   logic                  rst;
   logic [R-1:0]          req_vld;
   op_t  [R-1:0]          req_op;
   logic [R-1:0][4:0]     req_id;
   logic [R-1:0][W-1:0]   req_dat;
   logic [R-1:0]          req_acc;
   logic                  busy;
   logic                  cmd_pass_r;
   op_t                   cmd_op_r;
   logic [4:0]            cmd_id_r;
   logic [W-1:0]          cmd_dat_r;
   logic                  rsp_pass;
   logic [W-1:0]          rsp_dat;
   logic [R-1:0]          rsp_vld_r;
   logic [W-1:0]          rsp_dat_r;
   logic                  err_r;

   int n_checks = 0;
   int n_errors = 0;

   multi_counter_sched #(
      .W (W),
      .N (N),
      .R (R),
      .D (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_vld    (req_vld),
      .req_op     (req_op),
      .req_id     (req_id),
      .req_dat    (req_dat),
      .req_acc    (req_acc),
      .busy       (busy),
      .cmd_pass_r (cmd_pass_r),
      .cmd_op_r   (cmd_op_r),
      .cmd_id_r   (cmd_id_r),
      .cmd_dat_r  (cmd_dat_r),
      .rsp_pass   (rsp_pass),
      .rsp_dat    (rsp_dat),
      .rsp_vld_r  (rsp_vld_r),
      .rsp_dat_r  (rsp_dat_r),
      .err_r      (err_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_acc;
      rst      = 1'b1;
      busy     = 1'b0;
      rsp_pass = 1'b0;
      rsp_dat  = '0;
      req_vld  = 4'hF;
      for (int i = 0; i < 4; i++) begin
         req_op[i]  = OP_INIT;
         req_id[i]  = 5'(i + 4);
         req_dat[i] = 32'h100 + 32'(i);
      end

      // reset state
      @(posedge clk); #1;
      check("rst_acc", req_acc, 4'b0000);
      tick;
      check("rst_pass", cmd_pass_r, 1'b0);
      check("rst_rsp_vld", rsp_vld_r, 4'b0000);
      check("rst_err", err_r, 1'b0);
      check("rst_count", dut.u_tagq.count, 0);
      rst = 1'b0;

      // fairness: all four INCR
      for (int i = 0; i < 4; i++) req_op[i] = OP_INCR;
      req_vld = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_acc = 4'b0001 << (c % 4);
         check("fair_acc", req_acc, exp_acc);
         tick;
         check("fair_pass", cmd_pass_r, 1'b1);
         check("fair_op", cmd_op_r, OP_INCR);
         check("fair_id", cmd_id_r, (c % 4) + 4);
         check("fair_dat", cmd_dat_r, 32'h100 + (c % 4));
      end
      req_vld = '0;
      #1 check("idle_acc", req_acc, 4'b0000);
      tick;
      check("idle_pass", cmd_pass_r, 1'b0);
      check("idle_id_hold", cmd_id_r, 7);

      // busy stall
      req_op[2] = OP_DECR;
      req_vld   = 4'b0100;
      busy      = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 check("busy_acc", req_acc, 4'b0000);
         tick;
         check("busy_pass", cmd_pass_r, 1'b0);
      end
      busy = 1'b0;
      #1 check("unbusy_acc", req_acc, 4'b0100);
      tick;
      check("unbusy_pass", cmd_pass_r, 1'b1);
      check("unbusy_id", cmd_id_r, 6);
      check("unbusy_op", cmd_op_r, OP_DECR);
      req_vld = '0;

      // tag queue full
      req_op[1] = OP_QRY;
      req_vld   = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         #1 check("qfill_acc", req_acc, 4'b0010);
         tick;
         check("qfill_op", cmd_op_r, OP_QRY);
      end
      check("qfull_count", dut.u_tagq.count, 4);
      req_op[3] = OP_INCR;
      req_vld   = 4'b1010;
      #1 check("qfull_acc", req_acc, 4'b1000);
      tick;
      check("qfull_id", cmd_id_r, 7);
      check("qfull_op", cmd_op_r, OP_INCR);
      req_vld  = 4'b0010;
      rsp_pass = 1'b1;
      rsp_dat  = 32'h55;
      #1 check("qfull_rsp_acc", req_acc, 4'b0000);
      tick;
      check("qfull_rsp_vld", rsp_vld_r, 4'b0010);
      check("qfull_rsp_dat", rsp_dat_r, 32'h55);
      check("qfull_rsp_pass", cmd_pass_r, 1'b0);
      rsp_pass = 1'b0;
      #1 check("q5_acc", req_acc, 4'b0010);
      tick;
      check("q5_pass", cmd_pass_r, 1'b1);
      check("q5_count", dut.u_tagq.count, 4);
      req_vld = '0;
      for (int k = 0; k < 4; k++) begin
         rsp_pass = 1'b1;
         rsp_dat  = 32'h60 + 32'(k);
         tick;
         check("drain_vld", rsp_vld_r, 4'b0010);
         check("drain_dat", rsp_dat_r, 32'h60 + k);
      end
      rsp_pass = 1'b0;
      tick;
      check("drain_idle_vld", rsp_vld_r, 4'b0000);
      check("drain_count", dut.u_tagq.count, 0);

      // response ordering, with a push and pop in the same cycle
      req_op[0] = OP_QRY;
      req_op[2] = OP_QRY;
      req_vld   = 4'b0001;
      #1 check("ord_acc0", req_acc, 4'b0001);
      tick;
      req_vld = 4'b0100;
      #1 check("ord_acc2", req_acc, 4'b0100);
      tick;
      req_vld  = 4'b0010;
      rsp_pass = 1'b1;
      rsp_dat  = 32'hA;
      #1 check("ord_acc1", req_acc, 4'b0010);
      tick;
      check("ord_vld_a", rsp_vld_r, 4'b0001);
      check("ord_dat_a", rsp_dat_r, 32'hA);
      check("ord_count", dut.u_tagq.count, 2);
      req_vld = '0;
      rsp_dat = 32'hB;
      tick;
      check("ord_vld_b", rsp_vld_r, 4'b0100);
      check("ord_dat_b", rsp_dat_r, 32'hB);
      rsp_dat = 32'hC;
      tick;
      check("ord_vld_c", rsp_vld_r, 4'b0010);
      check("ord_dat_c", rsp_dat_r, 32'hC);
      rsp_pass = 1'b0;
      tick;
      check("ord_idle_vld", rsp_vld_r, 4'b0000);
      check("ord_err", err_r, 1'b0);

      // response with empty queue
      rsp_pass = 1'b1;
      rsp_dat  = 32'h77;
      tick;
      check("err_vld", rsp_vld_r, 4'b0000);
      check("err_set", err_r, 1'b1);
      check("err_dat_hold", rsp_dat_r, 32'hC);
      rsp_pass = 1'b0;
      tick;
      tick;
      check("err_sticky", err_r, 1'b1);

      // reset with two queries outstanding
      req_op[1] = OP_QRY;
      req_vld   = 4'b0011;
      #1 check("rmid_acc0", req_acc, 4'b0001);
      tick;
      #1 check("rmid_acc1", req_acc, 4'b0010);
      tick;
      check("rmid_count", dut.u_tagq.count, 2);
      rst     = 1'b1;
      req_vld = 4'hF;
      #1 check("rmid_rst_acc", req_acc, 4'b0000);
      tick;
      rst = 1'b0;
      check("rmid_count0", dut.u_tagq.count, 0);
      check("rmid_err0", err_r, 1'b0);
      check("rmid_pass0", cmd_pass_r, 1'b0);
      rsp_pass = 1'b1;
      rsp_dat  = 32'h99;
      #1 check("rmid_ptr0_acc", req_acc, 4'b0001);
      tick;
      check("rmid_err1", err_r, 1'b1);
      check("rmid_vld0", rsp_vld_r, 4'b0000);
      check("rmid_dat_hold", rsp_dat_r, 32'hC);
      check("rmid_count1", dut.u_tagq.count, 1);
      check("rmid_id", cmd_id_r, 4);
      req_vld = '0;
      rsp_dat = 32'h42;
      tick;
      check("rmid_vld1", rsp_vld_r, 4'b0001);
      check("rmid_dat", rsp_dat_r, 32'h42);
      check("rmid_err_sticky", err_r, 1'b1);
      rsp_pass = 1'b0;
      tick;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
